// File: rtl/karatsuba_mult_scheduler_pkg.sv
// Shared constants for the Karatsuba multiplier scheduler: operand widths and
// one-hot FSM state encodings.
package karatsuba_mult_scheduler_pkg;

    localparam int unsigned HALF_W = 16;
    localparam int unsigned FULL_W = 32;
    localparam int unsigned PROD_W = 2 * FULL_W;

    localparam logic [4:0] ST_IDLE = 5'b00001;
    localparam logic [4:0] ST_LL   = 5'b00010;
    localparam logic [4:0] ST_HH   = 5'b00100;
    localparam logic [4:0] ST_MID  = 5'b01000;
    localparam logic [4:0] ST_RESP = 5'b10000;

endpackage

// File: rtl/karatsuba_mult_scheduler_if.sv
// Request/response bundle between client engines (master) and the shared
// Karatsuba multiplier scheduler (slave).
interface karatsuba_mult_scheduler_if #(
    parameter int unsigned NREQ = 4
);
    import karatsuba_mult_scheduler_pkg::*;

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*FULL_W-1:0] req_a;
    logic [NREQ*FULL_W-1:0] req_b;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [IDW-1:0]         resp_id;
    logic [PROD_W-1:0]      resp_c;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_c
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_c
    );

endinterface

// File: rtl/adder_Nbit.sv
// Arithmetic library: W-bit unsigned adder, result wraps modulo 2^W.
module adder_Nbit #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/karatsuba_mult_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, searching circularly.
module karatsuba_mult_scheduler_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);
    logic [IDW-1:0] sel;
    logic           found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sel       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sel = IDW'((32'(ptr) + k) % NREQ);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end
endmodule

// File: rtl/mult_16.sv
// Arithmetic library: unsigned 16x16 -> 32 combinational multiplier.
module mult_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    assign p = 32'(a) * 32'(b);
endmodule

// File: rtl/karatsuba_mult_scheduler.sv
// Shares one 16x16 multiplier among NREQ clients; each accepted 32x32 product
// is built from three Karatsuba partial products over LL, HH and MID cycles.
module karatsuba_mult_scheduler
    import karatsuba_mult_scheduler_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic clk,
    input  logic rst,
    output logic busy,
    karatsuba_mult_scheduler_if.slave bus
);
    logic [4:0]          state, state_nxt;
    logic [IDW-1:0]      rr_ptr, id_q, grant_idx;
    logic [NREQ-1:0]     grant;
    logic [FULL_W-1:0]   a_q, b_q, ll_q, hh_q, mul_p;
    logic [HALF_W-1:0]   mul_x, mul_y;
    logic [HALF_W:0]     xs, ys;
    logic [FULL_W+1:0]   p_mid;
    logic [FULL_W:0]     m_mid;
    logic [PROD_W-1:0]   mid_sh, prod;
    logic                accept;

    karatsuba_mult_scheduler_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept         = (state == ST_IDLE) && (|bus.req_valid);
    assign bus.req_ready  = (state == ST_IDLE) ? grant : '0;
    assign bus.resp_valid = (state == ST_RESP);
    assign busy           = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|bus.req_valid) state_nxt = ST_LL;
            ST_LL:   state_nxt = ST_HH;
            ST_HH:   state_nxt = ST_MID;
            ST_MID:  state_nxt = ST_RESP;
            ST_RESP: if (bus.resp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Multiplier operands depend on state only; zero outside LL/HH/MID.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state)
            ST_LL:  begin mul_x = a_q[HALF_W-1:0];      mul_y = b_q[HALF_W-1:0];      end
            ST_HH:  begin mul_x = a_q[FULL_W-1:HALF_W]; mul_y = b_q[FULL_W-1:HALF_W]; end
            ST_MID: begin mul_x = xs[HALF_W-1:0];       mul_y = ys[HALF_W-1:0];       end
            default: ;
        endcase
    end

    mult_16 u_mul (.a(mul_x), .b(mul_y), .p(mul_p));

    adder_Nbit #(.W(HALF_W+1)) u_xs (
        .a({1'b0, a_q[FULL_W-1:HALF_W]}), .b({1'b0, a_q[HALF_W-1:0]}), .sum(xs));
    adder_Nbit #(.W(HALF_W+1)) u_ys (
        .a({1'b0, b_q[FULL_W-1:HALF_W]}), .b({1'b0, b_q[HALF_W-1:0]}), .sum(ys));

    // Fold the 17th sum bits back in so a 16x16 multiplier yields Xs*Ys.
    always_comb begin
        p_mid = {2'b00, mul_p};
        if (xs[HALF_W]) p_mid = p_mid + {2'b00, ys[HALF_W-1:0], 16'h0000};
        if (ys[HALF_W]) p_mid = p_mid + {2'b00, xs[HALF_W-1:0], 16'h0000};
        if (xs[HALF_W] && ys[HALF_W]) p_mid = p_mid + 34'h1_0000_0000;
        m_mid  = 33'(p_mid - {2'b00, ll_q} - {2'b00, hh_q});
        mid_sh = {15'h0000, m_mid, 16'h0000};
    end

    // HH<<32 and LL occupy disjoint bits, so they concatenate into one addend.
    adder_Nbit #(.W(PROD_W)) u_fin (.a({hh_q, ll_q}), .b(mid_sh), .sum(prod));

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ll_q        <= '0;
            hh_q        <= '0;
            bus.resp_c  <= '0;
            bus.resp_id <= '0;
        end else begin
            if (accept) begin
                a_q    <= bus.req_a[32'(grant_idx) * FULL_W +: FULL_W];
                b_q    <= bus.req_b[32'(grant_idx) * FULL_W +: FULL_W];
                id_q   <= grant_idx;
                rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state == ST_LL) ll_q <= mul_p;
            if (state == ST_HH) hh_q <= mul_p;
            if (state == ST_MID) begin
                bus.resp_c  <= prod;
                bus.resp_id <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_karatsuba_mult_scheduler.sv
// Self-checking bench for karatsuba_mult_scheduler: directed vector table,
// multi-cycle corner sequences and a scoreboarded random all-ports run.
module tb_karatsuba_mult_scheduler;
    import karatsuba_mult_scheduler_pkg::*;

    localparam int unsigned NREQ = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    karatsuba_mult_scheduler_if #(.NREQ(NREQ)) bus ();

    karatsuba_mult_scheduler #(.NREQ(NREQ)) dut (
        .clk  (clk),
        .rst  (rst),
        .busy (busy),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_c;
    } vec_t;

    typedef struct {
        int          id;
        logic [63:0] c;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  resp_count = 0;
    bit  rot_on = 1'b0;
    bit  rot_first = 1'b1;
    int  rot_prev = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL timeout_%s: expected event did not occur within the cycle budget", name);
    endtask

    task automatic set_op(input int port, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[32*port +: 32] = a;
        bus.req_b[32*port +: 32] = b;
    endtask

    // Observes handshakes mid-cycle: pushes expected products on accept, pops on response.
    task automatic monitor();
        sb_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                continue;
            end
            check("req_ready_legal",
                  64'({busy && (bus.req_ready != '0), !$onehot0(bus.req_ready),
                       (bus.req_ready & ~bus.req_valid) != '0}), 64'(0));
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_ready[i]) begin
                    e.id = i;
                    e.c  = 64'(bus.req_a[32*i +: 32]) * 64'(bus.req_b[32*i +: 32]);
                    sb.push_back(e);
                    if (rot_on) begin
                        if (!rot_first) check("grant_rotation", 64'(i), 64'((rot_prev + 1) % NREQ));
                        rot_first = 1'b0;
                        rot_prev  = i;
                    end
                end
            end
            if (bus.resp_valid && bus.resp_ready) begin
                resp_count++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_resp: got id %0d c 0x%0h, expected no response",
                             bus.resp_id, bus.resp_c);
                end else begin
                    e = sb.pop_front();
                    check("sb_resp_id", 64'(bus.resp_id), 64'(e.id));
                    check("sb_resp_c", bus.resp_c, e.c);
                end
            end
        end
    endtask

    task automatic wait_ready(input int port, input string name, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.req_ready[port]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_timeout(name);
    endtask

    // Called #1 after a posedge; returns #1 after the posedge where resp_valid is seen.
    task automatic wait_resp(input string name, output bit ok, output int lat);
        ok  = 1'b0;
        lat = 1;
        for (int k = 0; k < 20; k++) begin
            if (bus.resp_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!ok) fail_timeout(name);
    endtask

    task automatic run_one(input string name, input int port, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        bit ok;
        int lat;
        set_op(port, a, b);
        bus.req_valid[port] = 1'b1;
        wait_ready(port, name, ok);
        @(posedge clk); #1;
        bus.req_valid[port] = 1'b0;
        if (ok) begin
            wait_resp(name, ok, lat);
            if (ok) begin
                check({name, "_latency"}, 64'(lat), 64'(4));
                check({name, "_c"}, bus.resp_c, exp);
                check({name, "_id"}, 64'(bus.resp_id), 64'(port));
                @(posedge clk); #1;
            end
        end
    endtask

    vec_t vecs[8];

    initial begin
        bit          ok;
        int          lat;
        int          accepted;
        int          cyc;
        int          resp_before;
        logic [63:0] c0;
        logic [1:0]  id0;
        logic [NREQ-1:0] rdy;

        vecs[0] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{1, 32'h8000_8000, 32'h8000_8000, 64'h4000_8000_4000_0000};
        vecs[2] = '{2, 32'h0000_0000, 32'hDEAD_BEEF, 64'h0000_0000_0000_0000};
        vecs[3] = '{3, 32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0001};
        vecs[4] = '{0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        vecs[5] = '{2, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE};
        vecs[6] = '{1, 32'hFFFF_0000, 32'hFFFF_0000, 64'hFFFE_0001_0000_0000};
        vecs[7] = '{3, 32'h0001_0001, 32'h0000_FFFF, 64'h0000_0000_FFFF_FFFF};

        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("reset_resp_id", 64'(bus.resp_id), 64'(0));
        check("reset_resp_c", bus.resp_c, 64'(0));
        check("reset_req_ready", 64'(bus.req_ready), 64'(0));
        rst = 1'b0;

        for (int v = 0; v < 8; v++)
            run_one($sformatf("vec%0d", v), vecs[v].port, vecs[v].a, vecs[v].b, vecs[v].exp_c);

        // Ports 1 and 3 collide with rr_ptr freshly reset to 0.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_op(1, 32'h1234_5678, 32'h0000_0010);
        set_op(3, 32'h0000_0003, 32'h0000_0005);
        bus.req_valid = 4'b1010;
        @(negedge clk);
        check("collide_first_grant", 64'(bus.req_ready), 64'(4'b0010));
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        wait_resp("collide_p1", ok, lat);
        check("collide_p1_id", 64'(bus.resp_id), 64'(1));
        check("collide_p1_c", bus.resp_c, 64'h0000_0001_2345_6780);
        @(posedge clk); #1;
        @(negedge clk);
        check("collide_second_grant", 64'(bus.req_ready), 64'(4'b1000));
        @(posedge clk); #1;
        bus.req_valid[3] = 1'b0;
        wait_resp("collide_p3", ok, lat);
        check("collide_p3_id", 64'(bus.resp_id), 64'(3));
        check("collide_p3_c", bus.resp_c, 64'd15);
        @(posedge clk); #1;
        set_op(0, 32'h0000_0007, 32'h0000_0006);
        set_op(1, 32'h0000_0002, 32'h0000_0002);
        bus.req_valid = 4'b0011;
        @(negedge clk);
        check("ptr_wrapped_grant", 64'(bus.req_ready), 64'(4'b0001));
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_resp("ptr_wrap_p0", ok, lat);
        check("ptr_wrap_p0_c", bus.resp_c, 64'd42);
        @(posedge clk); #1;
        wait_ready(1, "ptr_wrap_p1", ok);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        wait_resp("ptr_wrap_p1", ok, lat);
        @(posedge clk); #1;

        // Response back-pressure while another requester waits.
        bus.resp_ready = 1'b0;
        set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bus.req_valid[2] = 1'b1;
        wait_ready(2, "stall_accept", ok);
        @(posedge clk); #1;
        bus.req_valid[2] = 1'b0;
        wait_resp("stall", ok, lat);
        c0  = bus.resp_c;
        id0 = bus.resp_id;
        check("stall_c", c0, 64'hFFFF_FFFE_0000_0001);
        set_op(0, 32'h0000_0100, 32'h0000_0100);
        bus.req_valid[0] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            check("stall_resp_valid", 64'(bus.resp_valid), 64'(1));
            check("stall_resp_c_hold", bus.resp_c, c0);
            check("stall_resp_id_hold", 64'(bus.resp_id), 64'(id0));
            check("stall_req_ready", 64'(bus.req_ready), 64'(0));
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_valid", 64'(bus.resp_valid), 64'(0));
        check("stall_release_c_kept", bus.resp_c, c0);
        wait_ready(0, "stall_next", ok);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_resp("stall_next", ok, lat);
        check("stall_next_c", bus.resp_c, 64'h0000_0000_0001_0000);
        @(posedge clk); #1;

        // Reset during HH discards the in-flight product.
        resp_before = resp_count;
        set_op(1, 32'hCAFE_F00D, 32'h1357_9BDF);
        bus.req_valid[1] = 1'b1;
        wait_ready(1, "rst_accept", ok);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("midrst_resp_c", bus.resp_c, 64'(0));
        check("midrst_resp_id", 64'(bus.resp_id), 64'(0));
        check("midrst_req_ready", 64'(bus.req_ready), 64'(0));
        rst = 1'b0;
        run_one("midrst_reissue", 1, 32'hCAFE_F00D, 32'h1357_9BDF,
                64'(32'hCAFE_F00D) * 64'(32'h1357_9BDF));
        repeat (10) @(posedge clk);
        #1;
        check("midrst_resp_count", 64'(resp_count - resp_before), 64'(1));

        // All ports request continuously with fresh random operands after each accept.
        rot_on    = 1'b1;
        rot_first = 1'b1;
        for (int p = 0; p < NREQ; p++) set_op(p, $urandom, $urandom);
        bus.req_valid = '1;
        accepted = 0;
        cyc      = 0;
        while (accepted < 1000 && cyc < 10000) begin
            @(negedge clk);
            rdy = bus.req_ready;
            @(posedge clk); #1;
            cyc++;
            for (int p = 0; p < NREQ; p++) begin
                if (rdy[p]) begin
                    accepted++;
                    set_op(p, $urandom, $urandom);
                end
            end
        end
        bus.req_valid = '0;
        rot_on = 1'b0;
        if (accepted < 1000) fail_timeout("random_accepts");
        for (int k = 0; k < 50; k++) begin
            if (!busy && sb.size() == 0) break;
            @(posedge clk); #1;
        end
        check("final_sb_drained", 64'(sb.size()), 64'(0));
        check("final_idle", 64'(busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
